instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 112 +++++++++++
 tb/tb_instr_encoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder feeding a DEPTH-entry output FIFO.
// Define INSTR_ENC_ILLEGAL_TRAP_EN to drop illegal kinds and pulse err instead of queueing a NOP.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_kind,
    input  logic [4:0]               req_rs,
    input  logic [4:0]               req_rt,
    input  logic [4:0]               req_rd,
    input  logic [25:0]              req_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   enc_word;
    logic          accept;
    logic          push;
    logic          pop;

    // Illegal kinds fall through to an all-zero word, which is the NOP.
    always_comb begin
        enc_word = '0;
        case (req_kind)
            4'd0: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
            4'd1: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100010};
            4'd2: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100100};
            4'd3: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100101};
            4'd4: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b101010};
            4'd5: enc_word = {6'b100011, req_rs, req_rt, req_imm[15:0]};
            4'd6: enc_word = {6'b101011, req_rs, req_rt, req_imm[15:0]};
            4'd7: enc_word = {6'b000100, req_rs, req_rt, req_imm[15:0]};
            4'd8: enc_word = {6'b001000, req_rs, req_rt, req_imm[15:0]};
            4'd9: enc_word = {6'b000010, req_imm};
            default: enc_word = '0;
        endcase
    end

    assign req_ready = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0000_0000;
    assign count     = count_q;
    assign err       = err_q;

    assign accept = req_valid && req_ready;
    assign pop    = out_valid && out_ready;

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    logic illegal;
    assign illegal = (req_kind > 4'd9);
    assign push    = accept && !illegal;
    assign err_d   = accept && illegal;
`else
    assign push    = accept;
    assign err_d   = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: out_instr is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model plus directed scenarios.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int FUNCT_TAB [5] = '{32, 34, 36, 37, 42};
    localparam int OP_TAB    [4] = '{35, 43, 4, 8};

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_kind;
    logic [4:0]    req_rs;
    logic [4:0]    req_rt;
    logic [4:0]    req_rd;
    logic [25:0]   req_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;
    logic          err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] model_q [$];
    bit          err_exp = 1'b0;
    bit          acc_m;
    bit          pop_m;
    bit          ill_m;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_rs    (req_rs),
        .req_rt    (req_rt),
        .req_rd    (req_rd),
        .req_imm   (req_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_model(input logic [3:0] kind, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [4:0] rd,
                                              input logic [25:0] imm);
        int k;
        k = int'(kind);
        if (k <= 4)
            return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(FUNCT_TAB[k]);
        else if (k <= 8)
            return (32'(OP_TAB[k-5]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm[15:0]);
        else if (k == 9)
            return 32'h0800_0000 | 32'(imm);
        else
            return 32'h0000_0000;
    endfunction

    // Reference model: FIFO as a queue, advanced on every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            model_q.delete();
            err_exp = 1'b0;
        end else begin
            acc_m   = req_valid && (model_q.size() < DEPTH);
            pop_m   = (model_q.size() != 0) && out_ready;
            ill_m   = (req_kind > 4'd9);
            err_exp = TRAP && acc_m && ill_m;
            if (pop_m) begin
                $display("pop    word=%h", model_q[0]);
                void'(model_q.pop_front());
            end
            if (acc_m && !(TRAP && ill_m)) begin
                model_q.push_back(enc_model(req_kind, req_rs, req_rt, req_rd, req_imm));
                $display("accept kind=%0d word=%h", req_kind,
                         enc_model(req_kind, req_rs, req_rt, req_rd, req_imm));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            chk("req_ready", 32'(req_ready), 32'(model_q.size() < DEPTH));
            chk("count", 32'(count), 32'(model_q.size()));
            chk("out_instr", out_instr, (model_q.size() != 0) ? model_q[0] : 32'h0);
            chk("err", 32'(err), 32'(err_exp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm);
        bit acc;
        bit done;
        done      = 1'b0;
        req_kind  = kind;
        req_rs    = rs;
        req_rt    = rt;
        req_rd    = rd;
        req_imm   = imm;
        req_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            acc = req_ready;
            step();
            done = acc;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_kind  = '0;
        req_rs    = '0;
        req_rt    = '0;
        req_rd    = '0;
        req_imm   = '0;
        out_ready = 1'b0;
        step();
        step();
        rst    = 1'b0;
        chk_en = 1'b1;

        chk("model_add",  enc_model(4'd0, 5'd1, 5'd2, 5'd3, 26'h0),      32'h0022_1820);
        chk("model_lw",   enc_model(4'd5, 5'd29, 5'd8, 5'd0, 26'h4),     32'h8FA8_0004);
        chk("model_j",    enc_model(4'd9, 5'd7, 5'd7, 5'd7, 26'h0100000), 32'h0810_0000);
        chk("model_sw",   enc_model(4'd6, 5'd1, 5'd2, 5'd9, 26'h3FF0010), 32'hAC22_0010);
        chk("model_beq",  enc_model(4'd7, 5'd3, 5'd4, 5'd7, 26'h000FFFF), 32'h1064_FFFF);
        chk("model_slt",  enc_model(4'd4, 5'd5, 5'd6, 5'd7, 26'h1234567), 32'h00A6_382A);

        // Latency 1 with a junk immediate on an R-type.
        req(4'd0, 5'd1, 5'd2, 5'd3, 26'h3FFFFFF);
        @(negedge clk);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_word", out_instr, 32'h0022_1820);
        out_ready = 1'b1;
        step();

        req(4'd5, 5'd29, 5'd8, 5'd31, 26'h0004);
        @(negedge clk);
        chk("lw_word", out_instr, 32'h8FA8_0004);
        req(4'd9, 5'd1, 5'd2, 5'd3, 26'h0100000);
        @(negedge clk);
        chk("j_word", out_instr, 32'h0810_0000);
        step();

        // Streaming at count==1: push and pop every cycle.
        req(4'd1, 5'd4, 5'd5, 5'd6, 26'h1);
        req(4'd2, 5'd7, 5'd8, 5'd9, 26'h2);
        req(4'd3, 5'd10, 5'd11, 5'd12, 26'h3);
        req(4'd6, 5'd13, 5'd14, 5'd15, 26'hABCD);
        req(4'd7, 5'd16, 5'd17, 5'd18, 26'h8001);
        req(4'd8, 5'd19, 5'd20, 5'd21, 26'hFFFF);
        repeat (3) step();

        // Fill to full, then release the consumer with one request waiting.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            req(4'd8, 5'(i), 5'(i + 1), 5'd9, 26'(16'h0100 + i));
        req_kind  = 4'd4;
        req_rs    = 5'd21;
        req_rt    = 5'd22;
        req_rd    = 5'd23;
        req_imm   = 26'h5;
        req_valid = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_ready", 32'(req_ready), 32'd0);
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("after_pop_count", 32'(count), 32'(DEPTH - 1));
        chk("after_pop_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        repeat (DEPTH + 2) step();

        // Hold at DEPTH-1 while pushing and popping across several pointer wraps.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++)
            req(4'd1, 5'(i), 5'(2 * i), 5'(3 * i), 26'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++)
            req(4'(i % 10), 5'(i + 3), 5'(31 - i), 5'(i * 2), 26'(32'h0012_3400 + i));
        @(negedge clk);
        chk("wrap_count", 32'(count), 32'(DEPTH - 1));
        repeat (DEPTH + 2) step();

        // Reset mid-push with three entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            req(4'd2, 5'(i + 1), 5'(i + 2), 5'(i + 3), 26'h0);
        req_kind  = 4'd0;
        req_valid = 1'b1;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_instr", out_instr, 32'h0);
        out_ready = 1'b1;
        repeat (4) step();

        // Illegal kind followed by a legal one.
        out_ready = 1'b0;
        req(4'd12, 5'd31, 5'd31, 5'd31, 26'h3FFFFFF);
        @(negedge clk);
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_count", 32'(count), 32'd0);
`else
        chk("ill_valid", 32'(out_valid), 32'd1);
        chk("ill_word", out_instr, 32'h0);
        chk("ill_err", 32'(err), 32'd0);
`endif
        req(4'd1, 5'd1, 5'd1, 5'd1, 26'h0);
        @(negedge clk);
        chk("ill_err_clear", 32'(err), 32'd0);
        out_ready = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
